// File: rtl/step_repeat_controller_pkg.sv
// ---------------------------------------------------------------------------
// step_repeat_controller_pkg
// Shared definitions for the step/repeat sequencer of the 4-bit counter:
// state encodings (also decoded by the debug LEDs), default tick counts and
// the saturate-at-limit test.
// ---------------------------------------------------------------------------
package step_repeat_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   localparam int DEF_TW           = 10;
   localparam int DEF_HOLD_TICKS   = 500;
   localparam int DEF_REPEAT_TICKS = 100;
   localparam int DEF_RUN_TICKS    = 250;

   localparam logic [3:0] CNT_MAX = 4'd15;
   localparam logic [3:0] CNT_MIN = 4'd0;

   // True when a pulse in the requested direction would push the counter
   // past its bound while saturation is enabled.
   function automatic logic limit_blocked(input logic       i_sat,
                                          input logic       i_dir,
                                          input logic [3:0] i_cnt);
      return i_sat && (i_dir ? (i_cnt == CNT_MAX) : (i_cnt == CNT_MIN));
   endfunction

endpackage

// File: rtl/step_repeat_controller_tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
// Down-counter advanced only on tick. A load of N makes expire fire on the
// N-th following tick. clear has priority over load, load over counting.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   tick     in   one-clk timer enable
//   load     in   load load_val into the timer
//   load_val in   reload value (TW bits)
//   clear    in   force the timer to 0 (idle)
//   expire   out  combinational: tick seen while timer == 1
// ---------------------------------------------------------------------------
module tick_timer #(
   parameter int TW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          clear,
   output logic          expire
);

   logic [TW-1:0] r_timer;

   assign expire = tick && (r_timer == TW'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timer <= '0;
      end else if (clear) begin
         r_timer <= '0;
      end else if (load) begin
         r_timer <= load_val;
      end else if (tick && (r_timer > TW'(1))) begin
         r_timer <= r_timer - TW'(1);
      end else if (expire) begin
         // Expired without a reload: park at 0 so it cannot fire again.
         r_timer <= '0;
      end
   end

endmodule

// File: rtl/step_repeat_controller.sv
// ---------------------------------------------------------------------------
// step_repeat_controller
// Turns the debounced step/run buttons into single-clk counter enables:
// one pulse per step press, auto-repeat while the step button is held, and a
// free-running RUN mode toggled by the run button. With saturate set, pulses
// that would move the counter past 15 (up) or 0 (down) are suppressed.
// Ports:
//   clk         in   1 MHz system clock
//   reset       in   asynchronous, active-low reset
//   tick        in   1 kHz one-clk enable for the interval timer
//   step_db     in   debounced step button (level)
//   run_db      in   debounced run button (level, press toggles RUN)
//   direction   in   1 = count up, 0 = count down
//   saturate    in   1 = stop at the bound, 0 = let the datapath wrap
//   count       in   current counter value from the datapath
//   count_pulse out  registered one-clk counter enable
//   count_up    out  registered direction qualifier for count_pulse
//   at_limit    out  registered "next pulse would be blocked" flag
//   state_o     out  current state for LEDs/debug
// ---------------------------------------------------------------------------
module step_repeat_controller
   import step_repeat_controller_pkg::*;
#(
   parameter int TW           = DEF_TW,
   parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
   parameter int RUN_TICKS    = DEF_RUN_TICKS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       step_db,
   input  logic       run_db,
   input  logic       direction,
   input  logic       saturate,
   input  logic [3:0] count,
   output logic       count_pulse,
   output logic       count_up,
   output logic       at_limit,
   output logic [1:0] state_o
);

   state_t        r_state;
   logic          r_step_d;
   logic          r_run_d;
   logic          r_count_pulse;
   logic          r_count_up;
   logic          r_at_limit;

   state_t        w_state_next;
   logic          w_step_rise;
   logic          w_run_rise;
   logic          w_blocked;
   logic          w_expire;
   logic          w_issue;
   logic          w_pulse;
   logic          w_load;
   logic [TW-1:0] w_load_val;
   logic          w_clear;

   // Edge detectors reset to 1 so a button held through reset is not a press.
   assign w_step_rise = step_db && !r_step_d;
   assign w_run_rise  = run_db  && !r_run_d;
   assign w_blocked   = limit_blocked(saturate, direction, count);

   // Blocked pulses are dropped; the previous-pulse term keeps count_pulse
   // from ever being high on two consecutive clks even with tiny tick counts.
   assign w_pulse = w_issue && !w_blocked && !r_count_pulse;

   tick_timer #(
      .TW(TW)
   ) u_tick_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .load     (w_load),
      .load_val (w_load_val),
      .clear    (w_clear),
      .expire   (w_expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_step_d      <= 1'b1;
         r_run_d       <= 1'b1;
         r_count_pulse <= 1'b0;
         r_count_up    <= 1'b0;
         r_at_limit    <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_step_d      <= step_db;
         r_run_d       <= run_db;
         r_count_pulse <= w_pulse;
         r_count_up    <= w_pulse ? direction : 1'b0;
         r_at_limit    <= w_blocked;
      end
   end

   // Every exit to IDLE clears the timer, which also makes an exit win over
   // a tick or expire arriving in the same clk.
   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_load       = 1'b0;
      w_load_val   = '0;
      w_clear      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_run_rise) begin
               w_load       = 1'b1;
               w_load_val   = TW'(RUN_TICKS);
               w_state_next = ST_RUN;
            end else if (w_step_rise) begin
               w_issue      = 1'b1;
               w_load       = 1'b1;
               w_load_val   = TW'(HOLD_TICKS);
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!step_db) begin
               w_clear      = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_expire) begin
               w_issue      = 1'b1;
               w_load       = 1'b1;
               w_load_val   = TW'(REPEAT_TICKS);
               w_state_next = ST_REPEAT;
            end
         end
         ST_REPEAT: begin
            if (!step_db) begin
               w_clear      = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_expire) begin
               w_issue    = 1'b1;
               w_load     = 1'b1;
               w_load_val = TW'(REPEAT_TICKS);
            end
         end
         ST_RUN: begin
            if (w_run_rise || w_step_rise) begin
               w_clear      = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_expire) begin
               if (w_blocked) begin
                  // Auto-stop once the counter has reached its bound.
                  w_clear      = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_issue    = 1'b1;
                  w_load     = 1'b1;
                  w_load_val = TW'(RUN_TICKS);
               end
            end
         end
         default: begin
            w_clear      = 1'b1;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign count_pulse = r_count_pulse;
   assign count_up    = r_count_up;
   assign at_limit    = r_at_limit;
   assign state_o     = r_state;

endmodule

// File: tb/tb_step_repeat_controller.sv
module tb_step_repeat_controller;

   localparam int HOLD_T   = 4;
   localparam int REPEAT_T = 2;
   localparam int RUN_T    = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       step_db = 1'b0;
   logic       run_db = 1'b0;
   logic       direction = 1'b1;
   logic       saturate = 1'b0;
   logic [3:0] count = 4'd0;
   logic       count_pulse;
   logic       count_up;
   logic       at_limit;
   logic [1:0] state_o;

   logic       cnt_load = 1'b0;
   logic [3:0] cnt_load_val = 4'd0;

   int n_checks = 0;
   int n_pass   = 0;
   int n_pulses = 0;
   int last_up  = -1;
   int tcnt     = 0;

   // behavioural model state
   int m_mode     = 0;  // 0 idle, 1 hold, 2 repeat, 3 run
   int m_elapsed  = 0;  // ticks counted since the current interval began
   bit m_step_prv = 1'b1;
   bit m_run_prv  = 1'b1;
   bit e_pulse    = 1'b0;
   bit e_up       = 1'b0;
   bit e_lim      = 1'b0;

   step_repeat_controller #(
      .TW(10), .HOLD_TICKS(HOLD_T), .REPEAT_TICKS(REPEAT_T), .RUN_TICKS(RUN_T)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .step_db(step_db), .run_db(run_db),
      .direction(direction), .saturate(saturate), .count(count),
      .count_pulse(count_pulse), .count_up(count_up), .at_limit(at_limit),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   // counter datapath enabled by count_pulse
   always @(posedge clk) begin
      if (cnt_load) count <= cnt_load_val;
      else if (count_pulse) count <= count_up ? count + 4'd1 : count - 4'd1;
   end

   // tick every 10 clks
   initial begin
      forever begin
         @(posedge clk);
         #2;
         tick = (tcnt == 9);
         tcnt = (tcnt + 1) % 10;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int period(input int mode);
      case (mode)
         1: return HOLD_T;
         2: return REPEAT_T;
         default: return RUN_T;
      endcase
   endfunction

   // Model: intervals are "N ticks after the interval began"; any exit to idle
   // forgets the interval.
   task automatic model_step();
      bit srise, rrise, blk, due, fire, restart;
      int nmode;
      if (!reset) begin
         m_mode = 0; m_elapsed = 0; m_step_prv = 1; m_run_prv = 1;
         e_pulse = 0; e_up = 0; e_lim = 0;
         return;
      end
      srise = step_db && !m_step_prv;
      rrise = run_db && !m_run_prv;
      blk   = saturate && (direction ? (count == 4'd15) : (count == 4'd0));
      due   = (m_mode != 0) && tick && (m_elapsed + 1 == period(m_mode));
      fire = 0; restart = 0; nmode = m_mode;
      case (m_mode)
         0: if (rrise) begin nmode = 3; restart = 1; end
            else if (srise) begin fire = 1; nmode = 1; restart = 1; end
         1: if (!step_db) nmode = 0;
            else if (due) begin fire = 1; nmode = 2; restart = 1; end
         2: if (!step_db) nmode = 0;
            else if (due) begin fire = 1; restart = 1; end
         default: if (rrise || srise) nmode = 0;
            else if (due) begin
               if (blk) nmode = 0;
               else begin fire = 1; restart = 1; end
            end
      endcase
      if (nmode == 0 || restart) m_elapsed = 0;
      else if (tick) m_elapsed++;
      e_pulse = fire && !blk && !e_pulse;
      e_up    = e_pulse ? direction : 1'b0;
      e_lim   = blk;
      m_mode  = nmode;
      m_step_prv = step_db;
      m_run_prv  = run_db;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         model_step();
      end
   end

   // compare every cycle, away from the active edge
   initial begin
      bit prev_pulse;
      prev_pulse = 0;
      forever begin
         @(negedge clk);
         check("count_pulse", int'(count_pulse), int'(e_pulse));
         check("state_o", int'(state_o), m_mode);
         check("at_limit", int'(at_limit), int'(e_lim));
         if (e_pulse) check("count_up", int'(count_up), int'(e_up));
         if (count_pulse) begin
            n_pulses++;
            last_up = int'(count_up);
            check("no_back_to_back", int'(prev_pulse), 0);
         end
         prev_pulse = count_pulse;
      end
   end

   task automatic clk_wait(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic load_count(input logic [3:0] v);
      cnt_load_val = v;
      cnt_load = 1'b1;
      clk_wait(1);
      cnt_load = 1'b0;
   endtask

   // position stimulus two clks after a tick so a press never shares a tick clk
   task automatic align_tick();
      int guard;
      guard = 0;
      while (!tick && guard < 20) begin
         clk_wait(1);
         guard++;
      end
      clk_wait(2);
   endtask

   initial begin
      int p0;
      #1000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      // reset
      reset = 1'b0;
      clk_wait(3);
      check("reset_state", int'(state_o), 0);
      check("reset_pulse", int'(count_pulse), 0);
      check("reset_limit", int'(at_limit), 0);
      reset = 1'b1;
      clk_wait(3);

      // single press
      direction = 1'b1; saturate = 1'b0;
      align_tick();
      p0 = n_pulses;
      step_db = 1'b1;
      clk_wait(2);
      check("single_state_hold", int'(state_o), 1);
      clk_wait(18);
      step_db = 1'b0;
      clk_wait(2);
      check("single_state_idle", int'(state_o), 0);
      clk_wait(40);
      check("single_pulses", n_pulses - p0, 1);
      check("single_dir", last_up, 1);

      // auto-repeat: 12 ticks held
      align_tick();
      p0 = n_pulses;
      step_db = 1'b1;
      clk_wait(125);
      check("repeat_state", int'(state_o), 2);
      step_db = 1'b0;
      clk_wait(1);
      check("repeat_release_idle", int'(state_o), 0);
      clk_wait(30);
      check("repeat_pulses", n_pulses - p0, 6);

      // RUN with saturate from 13
      saturate = 1'b1; direction = 1'b1;
      load_count(4'd13);
      clk_wait(2);
      p0 = n_pulses;
      run_db = 1'b1;
      clk_wait(5);
      check("run_state", int'(state_o), 3);
      run_db = 1'b0;
      clk_wait(100);
      check("run_pulses", n_pulses - p0, 2);
      check("run_count", int'(count), 15);
      check("run_autostop", int'(state_o), 0);
      check("run_at_limit", int'(at_limit), 1);

      // priority + wrap
      saturate = 1'b0; direction = 1'b0;
      load_count(4'd0);
      clk_wait(2);
      p0 = n_pulses;
      step_db = 1'b1; run_db = 1'b1;
      clk_wait(1);
      check("prio_state_run", int'(state_o), 3);
      clk_wait(1);
      check("prio_no_pulse", n_pulses - p0, 0);
      step_db = 1'b0; run_db = 1'b0;
      clk_wait(33);
      check("wrap_pulses", n_pulses - p0, 1);
      check("wrap_dir", last_up, 0);
      check("wrap_count", int'(count), 15);
      run_db = 1'b1;
      clk_wait(2);
      check("run_toggle_off", int'(state_o), 0);
      run_db = 1'b0;
      clk_wait(5);

      // reset mid-REPEAT with step held
      direction = 1'b1;
      align_tick();
      step_db = 1'b1;
      clk_wait(70);
      check("pre_reset_repeat", int'(state_o), 2);
      reset = 1'b0;
      #1;
      check("rst_async_state", int'(state_o), 0);
      clk_wait(5);
      check("rst_pulse", int'(count_pulse), 0);
      check("rst_up", int'(count_up), 0);
      check("rst_limit", int'(at_limit), 0);
      p0 = n_pulses;
      reset = 1'b1;
      clk_wait(80);
      check("post_reset_no_pulse", n_pulses - p0, 0);
      check("post_reset_idle", int'(state_o), 0);
      step_db = 1'b0;
      clk_wait(5);
      step_db = 1'b1;
      clk_wait(20);
      check("repress_pulse", n_pulses - p0, 1);
      step_db = 1'b0;
      clk_wait(5);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(29) == 0) step_db = ~step_db;
         if ($urandom_range(59) == 0) run_db = ~run_db;
         if ($urandom_range(49) == 0) direction = ~direction;
         if ($urandom_range(79) == 0) saturate = ~saturate;
         if ($urandom_range(99) == 0) begin
            cnt_load_val = ($urandom_range(1) == 0) ? 4'd0 : 4'd15;
            if ($urandom_range(2) == 0) cnt_load_val = 4'($urandom_range(15));
            cnt_load = 1'b1;
         end else begin
            cnt_load = 1'b0;
         end
         if ($urandom_range(599) == 0) begin
            reset = 1'b0;
            clk_wait($urandom_range(4, 1));
            reset = 1'b1;
         end
         clk_wait(1);
      end
      cnt_load = 1'b0;
      clk_wait(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
